// File: rtl/gcd_drain.sv
// Output stage after the last gcd pipeline stage: rebuilds |operand| << C, flags
// non-converged lanes, buffers results in a FIFO and stalls the pipeline when full.
module gcd_drain #(
  parameter  int unsigned DATA_WIDTH = 32,
  parameter  int unsigned DEPTH      = 4,
  localparam int unsigned ADDR_W     = $clog2(DEPTH)
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  In_valid,
  input  logic [DATA_WIDTH-1:0] Ain,
  input  logic [DATA_WIDTH-1:0] Bin,
  input  logic [DATA_WIDTH-1:0] Cin,
  output logic                  Pipe_en,
  output logic                  Out_valid,
  input  logic                  Out_ready,
  output logic [DATA_WIDTH-1:0] Gcd,
  output logic                  Gcd_err,
  output logic [ADDR_W:0]       Count
);

  localparam int unsigned      ENTRY_W = DATA_WIDTH + 1;
  localparam logic [ADDR_W:0]  FULL_L  = (ADDR_W+1)'(DEPTH);
  localparam logic [DATA_WIDTH-1:0] DW_L = DATA_WIDTH'(DATA_WIDTH);

  logic [ENTRY_W-1:0]    mem_q [DEPTH];
  logic [ADDR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]       count_q, count_d;

  logic [DATA_WIDTH-1:0] sel;
  logic [DATA_WIDTH-1:0] mag;
  logic [DATA_WIDTH-1:0] value;
  logic                  err;
  logic                  wr_en;
  logic                  rd_en;

  // Result reconstruction; a zero A means B carries the surviving odd factor.
  always_comb begin
    sel   = (Ain == '0) ? Bin : Ain;
    mag   = sel[DATA_WIDTH-1] ? -sel : sel;
    value = (Cin >= DW_L) ? '0 : (mag << Cin);
    err   = !((Ain == Bin) || (Ain == '0) || (Bin == '0));
  end

  // Flow control depends on registered occupancy only.
  assign Pipe_en   = (count_q != FULL_L);
  assign Out_valid = (count_q != '0);
  assign wr_en     = In_valid && Pipe_en;
  assign rd_en     = Out_valid && Out_ready;

  assign Gcd     = mem_q[rd_ptr_q][DATA_WIDTH-1:0];
  assign Gcd_err = mem_q[rd_ptr_q][DATA_WIDTH];
  assign Count   = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q + ADDR_W'(wr_en);
    rd_ptr_d = rd_ptr_q + ADDR_W'(rd_en);
    count_d  = count_q + (ADDR_W+1)'(wr_en) - (ADDR_W+1)'(rd_en);
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is cleared on reset so the idle head reads as zero.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (wr_en) begin
      mem_q[wr_ptr_q] <= {err, value};
    end
  end

endmodule

// File: tb/tb_gcd_drain.sv
// Directed bench for gcd_drain: vector table for the result rule, plus
// hand sequences for backpressure, concurrent read/write and async reset.
module tb_gcd_drain;

  localparam int unsigned DW = 32;

  logic          Clk;
  logic          Reset;
  logic          In_valid;
  logic [DW-1:0] Ain, Bin, Cin;
  logic          Pipe_en;
  logic          Out_valid;
  logic          Out_ready;
  logic [DW-1:0] Gcd;
  logic          Gcd_err;
  logic [2:0]    Count;

  int tests;
  int fails;

  gcd_drain #(.DATA_WIDTH(DW), .DEPTH(4)) dut (
    .Clk(Clk), .Reset(Reset), .In_valid(In_valid),
    .Ain(Ain), .Bin(Bin), .Cin(Cin),
    .Pipe_en(Pipe_en), .Out_valid(Out_valid), .Out_ready(Out_ready),
    .Gcd(Gcd), .Gcd_err(Gcd_err), .Count(Count)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic [DW-1:0] ain;
    logic [DW-1:0] bin;
    logic [DW-1:0] cin;
    logic [DW-1:0] gcd;
    logic          err;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge Clk);
    @(negedge Clk);
  endtask

  task automatic drive(input logic v, input logic [DW-1:0] a, input logic [DW-1:0] b,
                       input logic [DW-1:0] c, input logic rdy);
    In_valid  = v;
    Ain       = a;
    Bin       = b;
    Cin       = c;
    Out_ready = rdy;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    vecs[0] = '{32'd12,        32'd12,        32'd2,  32'd48,        1'b0};
    vecs[1] = '{32'd0,         32'hFFFF_FFFB, 32'd1,  32'd10,        1'b0};
    vecs[2] = '{32'd0,         32'd0,         32'd3,  32'd0,         1'b0};
    vecs[3] = '{32'd6,         32'd9,         32'd0,  32'd6,         1'b1};
    vecs[4] = '{32'hFFFF_FFF8, 32'd0,         32'd0,  32'd8,         1'b0};
    vecs[5] = '{32'd3,         32'd3,         32'd32, 32'd0,         1'b0};
    vecs[6] = '{32'd1,         32'd1,         32'd31, 32'h8000_0000, 1'b0};
    vecs[7] = '{32'hFFFF_FFFA, 32'd9,         32'd1,  32'd12,        1'b1};
    vecs[8] = '{32'd5,         32'd5,         32'd40, 32'd0,         1'b0};
    vecs[9] = '{32'h8000_0000, 32'd0,         32'd0,  32'h8000_0000, 1'b0};

    Reset = 1'b0;
    drive(1'b0, '0, '0, '0, 1'b0);
    @(negedge Clk);
    check("rst_out_valid", 32'(Out_valid), 32'd0);
    check("rst_gcd",       Gcd,            32'd0);
    check("rst_gcd_err",   32'(Gcd_err),   32'd0);
    check("rst_pipe_en",   32'(Pipe_en),   32'd1);
    check("rst_count",     32'(Count),     32'd0);
    Reset = 1'b1;
    cyc();

    // One triple at a time: visible right after the write edge, then drained.
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, vecs[i].ain, vecs[i].bin, vecs[i].cin, 1'b0);
      cyc();
      check($sformatf("vec%0d_valid", i), 32'(Out_valid), 32'd1);
      check($sformatf("vec%0d_gcd", i),   Gcd,            vecs[i].gcd);
      check($sformatf("vec%0d_err", i),   32'(Gcd_err),   32'(vecs[i].err));
      check($sformatf("vec%0d_count", i), 32'(Count),     32'd1);
      drive(1'b0, '0, '0, '0, 1'b1);
      cyc();
      check($sformatf("vec%0d_drained", i), 32'(Count), 32'd0);
    end
    drive(1'b0, '0, '0, '0, 1'b0);

    // Fill to DEPTH with the consumer stalled.
    for (int k = 1; k <= 4; k++) begin
      drive(1'b1, DW'(k), DW'(k), '0, 1'b0);
      cyc();
    end
    check("full_count",   32'(Count),   32'd4);
    check("full_pipe_en", 32'(Pipe_en), 32'd0);
    check("full_head",    Gcd,          32'd1);
    drive(1'b1, 32'd5, 32'd5, '0, 1'b0);
    cyc();
    check("held_count", 32'(Count), 32'd4);
    check("held_head",  Gcd,        32'd1);
    Out_ready = 1'b1;
    cyc();
    check("rd1_count",   32'(Count),   32'd3);
    check("rd1_pipe_en", 32'(Pipe_en), 32'd1);
    check("rd1_head",    Gcd,          32'd2);
    cyc();
    In_valid = 1'b0;
    check("rd2_count", 32'(Count), 32'd3);
    check("rd2_head",  Gcd,        32'd3);
    cyc();
    check("rd3_head", Gcd, 32'd4);
    cyc();
    check("rd4_head",  Gcd,        32'd5);
    check("rd4_count", 32'(Count), 32'd1);
    cyc();
    check("fill_empty", 32'(Out_valid), 32'd0);
    drive(1'b0, '0, '0, '0, 1'b0);

    // Steady-state read+write at Count=2, pointers wrap several times.
    for (int k = 10; k <= 11; k++) begin
      drive(1'b1, DW'(k), DW'(k), '0, 1'b0);
      cyc();
    end
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, DW'(12 + i), DW'(12 + i), '0, 1'b1);
      check($sformatf("rw%0d_head", i),  Gcd,        DW'(10 + i));
      check($sformatf("rw%0d_count", i), 32'(Count), 32'd2);
      cyc();
    end
    drive(1'b0, '0, '0, '0, 1'b1);
    check("rw_end_count", 32'(Count), 32'd2);
    check("rw_end_head",  Gcd,        32'd18);
    cyc();
    check("rw_last_head", Gcd, 32'd19);
    cyc();
    check("rw_drained", 32'(Count), 32'd0);
    drive(1'b0, '0, '0, '0, 1'b0);

    // Asynchronous reset with three entries buffered.
    for (int k = 7; k <= 9; k++) begin
      drive(1'b1, DW'(k), DW'(k), 32'd1, 1'b0);
      cyc();
    end
    drive(1'b0, '0, '0, '0, 1'b0);
    check("pre_rst_count", 32'(Count), 32'd3);
    check("pre_rst_head",  Gcd,        32'd14);
    #2 Reset = 1'b0;
    #1;
    check("arst_out_valid", 32'(Out_valid), 32'd0);
    check("arst_count",     32'(Count),     32'd0);
    check("arst_gcd",       Gcd,            32'd0);
    check("arst_pipe_en",   32'(Pipe_en),   32'd1);
    @(negedge Clk);
    cyc();
    Reset = 1'b1;
    drive(1'b1, 32'd21, 32'd21, '0, 1'b0);
    cyc();
    drive(1'b0, '0, '0, '0, 1'b0);
    check("post_rst_count", 32'(Count),   32'd1);
    check("post_rst_gcd",   Gcd,          32'd21);
    check("post_rst_err",   32'(Gcd_err), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/gcd_drain.md
Name: gcd_drain

Overview:
- Output stage placed directly after the last gcd pipeline stage.
- Takes the converged (A, B, C) triple and reconstructs the final GCD as |nonzero operand| << C, and flags lanes that did not converge.
- Buffers results in a small FIFO with a valid/ready output handshake.
- Drives the pipeline-wide Start enable, so the whole stage chain stalls when the buffer is full.

Parameters:
- DATA_WIDTH, 32, width of A/B/C and of the result.
- DEPTH, 4, FIFO entries; must be a power of two, >= 2.
- ADDR_W, $clog2(DEPTH), pointer width (derived, not overridden).

Ports:
- Clk  input  1  clock, rising edge.
- Reset  input  1  asynchronous, active-low reset.
- In_valid  input  1  valid tag that travelled with the triple through the pipeline.
- Ain  input  DATA_WIDTH  signed A from the last stage.
- Bin  input  DATA_WIDTH  signed B from the last stage.
- Cin  input  DATA_WIDTH  unsigned count of common factors of 2.
- Pipe_en  output  1  drives Start of every upstream stage and of the valid-tag shift register.
- Out_valid  output  1  head result available.
- Out_ready  input  1  consumer accepts head.
- Gcd  output  DATA_WIDTH  unsigned result at head.
- Gcd_err  output  1  head lane not converged.
- Count  output  ADDR_W+1  current FIFO occupancy.

Behaviour:
- Reset (async, Reset=0):
  - wr_ptr, rd_ptr, Count and all FIFO entries clear to 0.
  - Out_valid=0, Gcd=0, Gcd_err=0, Pipe_en=1.
  - A reset mid-operation discards all buffered results; the upstream pipeline is reset by the same signal.
- Pipe_en = (Count != DEPTH).
  - Combinational from registered state only; no path from In_valid or Out_ready.
  - Upstream stages hold while Pipe_en=0, so the triple presented is stable.
- Write: when In_valid=1 and Pipe_en=1, one entry is written at the rising edge and wr_ptr increments.
  - In_valid=1 with Pipe_en=0 is not a write.
  - The triple is still held upstream and is written once space frees, so no data is lost.
- Result computation (combinational, before the FIFO write):
  - sel = (Ain==0) ? Bin : Ain.
  - mag = |sel|, taken as two's-complement negate when sel is negative.
  - Gcd value = mag << Cin, truncated to DATA_WIDTH.
  - If Cin >= DATA_WIDTH, the value is 0.
  - Both operands zero gives value 0 with err=0.
- Err = !(Ain==Bin || Ain==0 || Bin==0). When err=1 the value is still computed from the same rule.
- Read: Out_valid = (Count != 0). Gcd and Gcd_err show the entry at rd_ptr.
  - On an edge with Out_valid=1 and Out_ready=1, rd_ptr increments.
  - Out_ready while empty has no effect.
- Latency: a triple written at edge t is visible on Gcd with Out_valid=1 after edge t (0 extra cycles), provided the FIFO was empty.
- Simultaneous write and read:
  - Count is unchanged and both pointers advance.
  - Legal at any 0 < Count < DEPTH.
  - When full, only a read can occur; Pipe_en rises on the cycle after the read.
- Pointers wrap modulo DEPTH. Count never exceeds DEPTH and never underflows.
- Output order equals input order.
- Gcd and Gcd_err are held stable while Out_valid=1 and Out_ready=0.

Test Plan:
1. Equal operands: Ain=12, Bin=12, Cin=2, In_valid pulse -> next cycle Out_valid=1, Gcd=48, Gcd_err=0, Count=1.
2. Zero and negative operand: Ain=0, Bin=-5, Cin=1 -> Gcd=10, Gcd_err=0. Then Ain=0, Bin=0, Cin=3 -> Gcd=0, Gcd_err=0.
3. Non-converged lane: Ain=6, Bin=9, Cin=0 -> Gcd=6, Gcd_err=1.
4. Fill and backpressure:
   - Stimulus: Out_ready=0, write results 1, 2, 3, 4 (Ain=Bin=k, Cin=0).
   - Required: Count=4, Pipe_en=0; a fifth triple Ain=Bin=5 held with In_valid=1 is not written.
   - Then Out_ready=1: outputs 1, 2, 3, 4, 5 in order, and Pipe_en rises one cycle after the first read.
5. Simultaneous read/write at Count=2 over 8 cycles -> Count stays 2, outputs stay in order, and the pointers wrap cleanly past DEPTH.
6. Reset mid-operation: Count=3, then assert Reset=0 asynchronously between edges -> immediately Out_valid=0, Count=0, Gcd=0, Pipe_en=1; after release, the first new write appears correctly.
